// File: rtl/smart_mac_nreg.sv
// smart_mac_nreg: multi-region secure memory access controller.
// Guards up to four key/data areas, each owned by one code range that may only
// be entered through its first address. Illegal accesses blank read data and
// raise a stretched, debug-maskable reset while recording cause and region.
// Optional feature: define SMART_MAC_CODE_WP_EN to treat data writes into any
// code range as a violation (cause 11).
module smart_mac_nreg #(
  parameter int          NUM_REGIONS   = 1,
  parameter int          SIZE_MEM_ADDR = 15,
  parameter logic [63:0] LOW_SAFE      = {4{16'd200}},
  parameter logic [63:0] HIGH_SAFE     = {4{16'd200}},
  parameter logic [63:0] LOW_CODE      = {4{16'd200}},
  parameter logic [63:0] HIGH_CODE     = {4{16'd200}},
  parameter int          RESET_CYCLES  = 8
) (
  input  logic                   mclk,
  input  logic                   puc_rst,
  input  logic [SIZE_MEM_ADDR:0] mem_addr,
  input  logic                   mem_en,
  input  logic                   mem_wr,
  input  logic [15:0]            mem_din,
  input  logic [15:0]            ins_addr,
  input  logic                   disable_debug,
  output logic [15:0]            mem_dout,
  output logic                   reset,
  output logic                   in_safe_area,
  output logic [1:0]             active_region,
  output logic                   in_region,
  output logic [1:0]             viol_cause,
  output logic [1:0]             viol_region
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  region_q, region_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [1:0]  vreg_q, vreg_d;
  logic        pulse_q, pulse_d;

  logic [15:0] addr16;
  logic [3:0]  in_code, in_safe, entry_hit, code_wr_hit, owns;
  logic [3:0]  entry_v, wr_v, data_v;
  logic        viol;
  logic [1:0]  viol_cause_c, viol_idx_c, entry_idx;

  assign addr16 = 16'(mem_addr);

  // Lowest set index wins when several regions match.
  function automatic logic [1:0] first_idx(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Per-region address decode; regions beyond NUM_REGIONS never match.
  always_comb begin
    in_code     = '0;
    in_safe     = '0;
    entry_hit   = '0;
    code_wr_hit = '0;
    owns        = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < NUM_REGIONS) begin
        in_code[j]     = (ins_addr >= LOW_CODE[16*j +: 16]) && (ins_addr <= HIGH_CODE[16*j +: 16]);
        entry_hit[j]   = (ins_addr == LOW_CODE[16*j +: 16]);
        in_safe[j]     = (addr16 >= LOW_SAFE[16*j +: 16]) && (addr16 <= HIGH_SAFE[16*j +: 16]);
        code_wr_hit[j] = (addr16 >= LOW_CODE[16*j +: 16]) && (addr16 <= HIGH_CODE[16*j +: 16]);
        owns[j]        = (state_q == ST_ACTIVE) && (region_q == 2'(j));
      end
    end
  end

  // Violation detection and priority: entry, then code write, then data.
  always_comb begin
    entry_v = in_code & ~entry_hit & ~owns;
    data_v  = {4{mem_en}} & in_safe & ~owns;
`ifdef SMART_MAC_CODE_WP_EN
    wr_v    = {4{mem_en & mem_wr}} & code_wr_hit;
`else
    wr_v    = '0;
`endif
    viol         = (|entry_v) | (|wr_v) | (|data_v);
    viol_cause_c = 2'b00;
    viol_idx_c   = 2'd0;
    if (|entry_v) begin
      viol_cause_c = 2'b10;
      viol_idx_c   = first_idx(entry_v);
    end else if (|wr_v) begin
      viol_cause_c = 2'b11;
      viol_idx_c   = first_idx(wr_v);
    end else if (|data_v) begin
      viol_cause_c = 2'b01;
      viol_idx_c   = first_idx(data_v);
    end
    entry_idx = first_idx(entry_hit);
  end

`ifndef SMART_MAC_CODE_WP_EN
  // Write qualifier and code-range write decode only matter with write protection.
  logic unused_wr;
  assign unused_wr = mem_wr ^ (|code_wr_hit);
`endif

  // Next-state logic: HOLD counts down; otherwise violations win over region moves.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    vreg_d   = vreg_q;
    pulse_d  = 1'b0;
    if (state_q == ST_HOLD) begin
      if (cnt_q == 8'd0) state_d = ST_IDLE;
      else               cnt_d   = cnt_q - 8'd1;
    end else if (viol) begin
      cause_d = viol_cause_c;
      vreg_d  = viol_idx_c;
      if (disable_debug) begin
        state_d = ST_IDLE;
        pulse_d = 1'b1;
      end else begin
        state_d = ST_HOLD;
        cnt_d   = 8'(RESET_CYCLES - 1);
      end
    end else if (|entry_hit) begin
      state_d  = ST_ACTIVE;
      region_d = entry_idx;
    end else if ((state_q == ST_ACTIVE) && !in_code[region_q]) begin
      state_d = ST_IDLE;
    end
  end

  // State, counter and violation record registers.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q  <= ST_IDLE;
      region_q <= 2'd0;
      cnt_q    <= 8'd0;
      cause_q  <= 2'b00;
      vreg_q   <= 2'd0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      vreg_q   <= vreg_d;
      pulse_q  <= pulse_d;
    end
  end

  // Outputs: reset is masked by debug; read data is blanked combinationally.
  always_comb begin
    reset         = (state_q == ST_HOLD) && !disable_debug;
    in_safe_area  = (state_q == ST_HOLD) || pulse_q;
    in_region     = (state_q == ST_ACTIVE);
    active_region = in_region ? region_q : 2'd0;
    viol_cause    = cause_q;
    viol_region   = vreg_q;
    mem_dout      = ((|data_v) || reset) ? 16'h0000 : mem_din;
  end

endmodule

// File: tb/tb_smart_mac_nreg.sv
// Directed bench for smart_mac_nreg: table of per-cycle vectors plus hand
// sequences for debug masking, asynchronous reset mid-HOLD and code writes.
module tb_smart_mac_nreg;

  logic        mclk, puc_rst;
  logic [15:0] mem_addr, mem_din, ins_addr, mem_dout;
  logic        mem_en, mem_wr, disable_debug;
  logic        reset, in_safe_area, in_region;
  logic [1:0]  active_region, viol_cause, viol_region;

  int checks = 0;
  int errors = 0;

  smart_mac_nreg #(
    .NUM_REGIONS  (2),
    .SIZE_MEM_ADDR(15),
    .LOW_SAFE     ({16'd200, 16'd200, 16'h0310, 16'h0300}),
    .HIGH_SAFE    ({16'd200, 16'd200, 16'h031F, 16'h030F}),
    .LOW_CODE     ({16'd200, 16'd200, 16'h0200, 16'h0100}),
    .HIGH_CODE    ({16'd200, 16'd200, 16'h02FF, 16'h01FF}),
    .RESET_CYCLES (8)
  ) dut (
    .mclk(mclk), .puc_rst(puc_rst), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_wr(mem_wr), .mem_din(mem_din), .ins_addr(ins_addr),
    .disable_debug(disable_debug), .mem_dout(mem_dout), .reset(reset),
    .in_safe_area(in_safe_area), .active_region(active_region),
    .in_region(in_region), .viol_cause(viol_cause), .viol_region(viol_region)
  );

  // Clock and reset
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic [15:0] ins;
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        dd;
    logic [15:0] e_dout;
    logic        e_rst;
    logic        e_safe;
    logic        e_inr;
    logic [1:0]  e_ar;
    logic [1:0]  e_cause;
    logic [1:0]  e_vr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [15:0] ins, input logic en, input logic wr,
                              input logic [15:0] addr, input logic [15:0] din, input logic dd,
                              input logic [15:0] e_dout, input logic e_rst, input logic e_safe,
                              input logic e_inr, input logic [1:0] e_ar, input logic [1:0] e_cause,
                              input logic [1:0] e_vr);
    vec_t v;
    v.ins = ins; v.en = en; v.wr = wr; v.addr = addr; v.din = din; v.dd = dd;
    v.e_dout = e_dout; v.e_rst = e_rst; v.e_safe = e_safe; v.e_inr = e_inr;
    v.e_ar = e_ar; v.e_cause = e_cause; v.e_vr = e_vr;
    vecs.push_back(v);
  endfunction

  // Driver: inputs change after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [15:0] ins, input logic en, input logic wr,
                       input logic [15:0] addr, input logic [15:0] din, input logic dd);
    @(negedge mclk);
    ins_addr = ins; mem_en = en; mem_wr = wr; mem_addr = addr;
    mem_din = din; disable_debug = dd;
    #1;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_dout, input logic e_rst,
                         input logic e_safe, input logic e_inr, input logic [1:0] e_ar,
                         input logic [1:0] e_cause, input logic [1:0] e_vr);
    chk({tag, ".mem_dout"}, mem_dout, e_dout);
    chk({tag, ".reset"}, 16'(reset), 16'(e_rst));
    chk({tag, ".in_safe_area"}, 16'(in_safe_area), 16'(e_safe));
    chk({tag, ".in_region"}, 16'(in_region), 16'(e_inr));
    chk({tag, ".active_region"}, 16'(active_region), 16'(e_ar));
    chk({tag, ".viol_cause"}, 16'(viol_cause), 16'(e_cause));
    chk({tag, ".viol_region"}, 16'(viol_region), 16'(e_vr));
  endtask

  initial begin
    puc_rst = 1'b1; ins_addr = 16'h0000; mem_en = 1'b0; mem_wr = 1'b0;
    mem_addr = 16'h0000; mem_din = 16'h1111; disable_debug = 1'b0;

    // ins, en, wr, addr, din, dd | dout, rst, safe, inr, ar, cause, vr
    // Legal entry into region 0, then read of its safe area
    add(16'h000, 0, 0, 16'h000, 16'h1111, 0,  16'h1111, 0, 0, 0, 0, 2'b00, 0);
    add(16'h100, 0, 0, 16'h000, 16'h1111, 0,  16'h1111, 0, 0, 0, 0, 2'b00, 0);
    add(16'h120, 1, 0, 16'h304, 16'hBEEF, 0,  16'hBEEF, 0, 0, 1, 0, 2'b00, 0);
    // Cross-region data read from ACTIVE(0) into region 1's safe area
    add(16'h130, 1, 0, 16'h314, 16'hBEEF, 0,  16'h0000, 0, 0, 1, 0, 2'b00, 0);
    for (int i = 0; i < 8; i++) begin
      // An entry violation mid-HOLD must be ignored
      if (i == 2) add(16'h150, 0, 0, 16'h000, 16'h2222, 0, 16'h0000, 1, 1, 0, 0, 2'b01, 1);
      else        add(16'h000, 0, 0, 16'h000, 16'h2222, 0, 16'h0000, 1, 1, 0, 0, 2'b01, 1);
    end
    add(16'h000, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 0, 0, 2'b01, 1);
    // Data violation from IDLE
    add(16'h000, 1, 0, 16'h304, 16'hBEEF, 0,  16'h0000, 0, 0, 0, 0, 2'b01, 1);
    for (int i = 0; i < 8; i++)
      add(16'h000, 0, 0, 16'h000, 16'h2222, 0, 16'h0000, 1, 1, 0, 0, 2'b01, 0);
    add(16'h000, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 0, 0, 2'b01, 0);
    // Entry violation from IDLE
    add(16'h150, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 0, 0, 2'b01, 0);
    for (int i = 0; i < 8; i++)
      add(16'h000, 0, 0, 16'h000, 16'h2222, 0, 16'h0000, 1, 1, 0, 0, 2'b10, 0);
    add(16'h000, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 0, 0, 2'b10, 0);
    // Enter region 0, jump to region 1's entry, read its safe area, then exit
    add(16'h100, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 0, 0, 2'b10, 0);
    add(16'h120, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 1, 0, 2'b10, 0);
    add(16'h200, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 1, 0, 2'b10, 0);
    add(16'h210, 1, 0, 16'h314, 16'hBEEF, 0,  16'hBEEF, 0, 0, 1, 1, 2'b10, 0);
    add(16'h000, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 1, 1, 2'b10, 0);
    add(16'h000, 0, 0, 16'h000, 16'h2222, 0,  16'h2222, 0, 0, 0, 0, 2'b10, 0);

    // Reset state
    repeat (2) @(negedge mclk);
    #1;
    chk_all("reset_state", 16'h1111, 0, 0, 0, 0, 2'b00, 0);
    @(negedge mclk);
    puc_rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ins, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].dd);
      chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_rst, vecs[i].e_safe,
              vecs[i].e_inr, vecs[i].e_ar, vecs[i].e_cause, vecs[i].e_vr);
    end

    // Debug-masked data violation: blanked read, 1-cycle pulse, no reset
    drive(16'h000, 1, 0, 16'h304, 16'hBEEF, 1);
    chk_all("mask_cycle0", 16'h0000, 0, 0, 0, 0, 2'b10, 0);
    drive(16'h000, 0, 0, 16'h000, 16'h2222, 1);
    chk_all("mask_cycle1", 16'h2222, 0, 1, 0, 0, 2'b01, 0);
    drive(16'h000, 0, 0, 16'h000, 16'h2222, 1);
    chk_all("mask_cycle2", 16'h2222, 0, 0, 0, 0, 2'b01, 0);

    // Raising disable_debug mid-HOLD drops reset but the counter keeps running
    drive(16'h150, 0, 0, 16'h000, 16'h2222, 0);
    for (int i = 0; i < 3; i++) begin
      drive(16'h000, 0, 0, 16'h000, 16'h2222, 0);
      chk_all($sformatf("hold_dd0_%0d", i), 16'h0000, 1, 1, 0, 0, 2'b10, 0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(16'h000, 0, 0, 16'h000, 16'h2222, 1);
      chk_all($sformatf("hold_dd1_%0d", i), 16'h2222, 0, 1, 0, 0, 2'b10, 0);
    end
    drive(16'h000, 0, 0, 16'h000, 16'h2222, 1);
    chk_all("hold_dd1_done", 16'h2222, 0, 0, 0, 0, 2'b10, 0);

    // Asynchronous puc_rst in the middle of HOLD
    drive(16'h000, 1, 0, 16'h314, 16'hBEEF, 0);
    chk_all("prehold", 16'h0000, 0, 0, 0, 0, 2'b10, 0);
    drive(16'h000, 0, 0, 16'h000, 16'h2222, 0);
    chk_all("hold_before_rst", 16'h0000, 1, 1, 0, 0, 2'b01, 1);
    drive(16'h000, 0, 0, 16'h000, 16'h2222, 0);
    #1 puc_rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h2222, 0, 0, 0, 0, 2'b00, 0);
    @(negedge mclk);
    puc_rst = 1'b0;
    drive(16'h000, 0, 0, 16'h000, 16'h2222, 0);
    chk_all("after_rst", 16'h2222, 0, 0, 0, 0, 2'b00, 0);

    // Write into region 0's code range while executing it
    drive(16'h100, 0, 0, 16'h000, 16'h3333, 0);
    drive(16'h120, 0, 0, 16'h000, 16'h3333, 0);
    chk_all("wp_active", 16'h3333, 0, 0, 1, 0, 2'b00, 0);
    drive(16'h130, 1, 1, 16'h110, 16'h3333, 0);
    chk_all("wp_write", 16'h3333, 0, 0, 1, 0, 2'b00, 0);
    drive(16'h130, 0, 0, 16'h000, 16'h3333, 0);
`ifdef SMART_MAC_CODE_WP_EN
    chk_all("wp_result", 16'h0000, 1, 1, 0, 0, 2'b11, 0);
`else
    chk_all("wp_result", 16'h3333, 0, 0, 1, 0, 2'b00, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
